// File: rtl/otter_csr_file_if.sv
// CSR access bus between the core datapath and the CSR file.
// Carries the commit-stage write request and the combinational read-back.
// No handshake: a request is consumed in the cycle w_en is high.
interface otter_csr_file_if;
  logic        w_en;
  logic [1:0]  w_op;
  logic [11:0] addr;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        csr_illegal;

  modport master (
    output w_en, w_op, addr, w_data,
    input  r_data, csr_illegal
  );

  modport slave (
    input  w_en, w_op, addr, w_data,
    output r_data, csr_illegal
  );
endinterface

// File: rtl/otter_csr_file.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc/mcause/mip plus mcycle/minstret.
// Latency: reads are combinational (pre-write value), writes land on the next edge.
// No backpressure: every request and trap/mret event is accepted in its cycle.
module otter_csr_file #(
  parameter int          NUM_IRQ     = 4,
  parameter int          COUNTER_EN  = 1,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  otter_csr_file_if.slave    bus,
  input  logic [31:0]        prog_count,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               intrpt_taken,
  input  logic               mret,
  input  logic               instr_retire,
  output logic [31:0]        csr_mepc,
  output logic [31:0]        csr_mtvec,
  output logic               intrpt_pending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic               st_mie;
  logic               st_mpie;
  logic [NUM_IRQ-1:0] mie_irq;
  logic [NUM_IRQ-1:0] mip_irq;
  logic [31:0]        mtvec;
  logic [31:0]        mepc;
  logic [31:0]        mcause;
  logic [63:0]        mcycle;
  logic [63:0]        minstret;

  logic [31:0]        rd_val;
  logic               rd_illegal;
  logic [31:0]        wr_val;
  logic               wr;
  logic [NUM_IRQ-1:0] pend;
  logic [4:0]         irq_code;
  logic [31:0]        trap_cause;

  // Read mux over the current register values; unmapped addresses read 0 and flag illegal.
  always_comb begin
    rd_val     = 32'd0;
    rd_illegal = 1'b0;
    case (bus.addr)
      A_MSTATUS:   rd_val = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
      A_MIE:       rd_val = 32'(mie_irq) << 16;
      A_MTVEC:     rd_val = mtvec;
      A_MEPC:      rd_val = mepc;
      A_MCAUSE:    rd_val = mcause;
      A_MIP:       rd_val = 32'(mip_irq) << 16;
      A_MCYCLE:    rd_val = mcycle[31:0];
      A_MCYCLEH:   rd_val = mcycle[63:32];
      A_MINSTRET:  rd_val = minstret[31:0];
      A_MINSTRETH: rd_val = minstret[63:32];
      default:     rd_illegal = 1'b1;
    endcase
  end

  assign bus.r_data      = rd_val;
  assign bus.csr_illegal = rd_illegal;

  // New value for csrrw/csrrs/csrrc, built from the pre-write read value.
  always_comb begin
    wr_val = rd_val;
    case (bus.w_op)
      2'b00:   wr_val = bus.w_data;
      2'b01:   wr_val = rd_val | bus.w_data;
      2'b10:   wr_val = rd_val & ~bus.w_data;
      default: wr_val = rd_val;
    endcase
  end

  assign wr = bus.w_en && (bus.w_op != 2'b11);

  // Lowest-numbered enabled pending line decides the trap cause (scan high to low).
  always_comb begin
    irq_code = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_code = 5'(16 + i);
    end
  end

  assign pend           = mip_irq & mie_irq;
  assign trap_cause     = (|pend) ? {1'b1, 26'd0, irq_code} : 32'h8000_0000;
  assign intrpt_pending = st_mie & (|pend);
  assign csr_mepc       = mepc;
  assign csr_mtvec      = mtvec;

  // Trap-related state: trap entry beats mret, which beats a CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      mepc    <= 32'd0;
      mcause  <= 32'd0;
    end else if (intrpt_taken) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
      mepc    <= prog_count & ~32'd3;
      mcause  <= trap_cause;
    end else if (mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr) begin
      if (bus.addr == A_MSTATUS) begin
        st_mie  <= wr_val[3];
        st_mpie <= wr_val[7];
      end
      if (bus.addr == A_MEPC)   mepc   <= wr_val & ~32'd3;
      if (bus.addr == A_MCAUSE) mcause <= wr_val;
    end
  end

  // Enables, vector base and sampled interrupt lines; unaffected by trap/mret.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_irq <= '0;
      mip_irq <= '0;
      mtvec   <= MTVEC_RESET & ~32'd3;
    end else begin
      mip_irq <= irq;
      if (wr && bus.addr == A_MIE)   mie_irq <= wr_val[16 +: NUM_IRQ];
      if (wr && bus.addr == A_MTVEC) mtvec   <= wr_val & ~32'd3;
    end
  end

  // Cycle counter: a write to either half replaces it and skips that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle <= 64'd0;
    end else if (COUNTER_EN == 0) begin
      mcycle <= 64'd0;
    end else if (wr && bus.addr == A_MCYCLE) begin
      mcycle[31:0] <= wr_val;
    end else if (wr && bus.addr == A_MCYCLEH) begin
      mcycle[63:32] <= wr_val;
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

  // Retired-instruction counter, same write-overrides-increment rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minstret <= 64'd0;
    end else if (COUNTER_EN == 0) begin
      minstret <= 64'd0;
    end else if (wr && bus.addr == A_MINSTRET) begin
      minstret[31:0] <= wr_val;
    end else if (wr && bus.addr == A_MINSTRETH) begin
      minstret[63:32] <= wr_val;
    end else if (instr_retire) begin
      minstret <= minstret + 64'd1;
    end
  end

endmodule

// File: tb/tb_otter_csr_file.sv
// Self-checking bench for otter_csr_file: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the CSR rules.
module tb_otter_csr_file;
  localparam int          NIRQ   = 4;
  localparam logic [31:0] MTVR   = 32'h0000_0100;
  localparam logic [31:0] IMASK  = 32'h000F_0000;

  logic            clk;
  logic            rst_n;
  logic [31:0]     prog_count;
  logic [NIRQ-1:0] irq;
  logic            intrpt_taken;
  logic            mret;
  logic            instr_retire;
  logic [31:0]     csr_mepc;
  logic [31:0]     csr_mtvec;
  logic            intrpt_pending;

  otter_csr_file_if bus ();

  otter_csr_file #(.NUM_IRQ(NIRQ), .COUNTER_EN(1), .MTVEC_RESET(MTVR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .prog_count(prog_count), .irq(irq),
    .intrpt_taken(intrpt_taken), .mret(mret), .instr_retire(instr_retire),
    .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec), .intrpt_pending(intrpt_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_r, m_mip, m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mie_r = 0; m_mip = 0;
    m_mtvec = MTVR; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ret = 0;
  endtask

  function automatic logic m_legal(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mpie) * 128) + (32'(m_mie) * 8);
      12'h304: return m_mie_r;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge's worth of architectural rules to the model.
  task automatic model_update();
    logic [31:0] old, nv, pend;
    logic        w, found;
    old = m_read(bus.addr);
    case (bus.w_op)
      2'd0:    nv = bus.w_data;
      2'd1:    nv = old | bus.w_data;
      2'd2:    nv = old & ~bus.w_data;
      default: nv = old;
    endcase
    w    = bus.w_en && (bus.w_op != 2'd3);
    pend = m_mip & m_mie_r;
    if (w && bus.addr == 12'hB00)      m_cyc = {m_cyc[63:32], nv};
    else if (w && bus.addr == 12'hB80) m_cyc = {nv, m_cyc[31:0]};
    else                               m_cyc = m_cyc + 64'd1;
    if (w && bus.addr == 12'hB02)      m_ret = {m_ret[63:32], nv};
    else if (w && bus.addr == 12'hB82) m_ret = {nv, m_ret[31:0]};
    else if (instr_retire)             m_ret = m_ret + 64'd1;
    if (w && bus.addr == 12'h304) m_mie_r = nv & IMASK;
    if (w && bus.addr == 12'h305) m_mtvec = nv & 32'hFFFF_FFFC;
    if (intrpt_taken) begin
      m_mepc   = prog_count & 32'hFFFF_FFFC;
      m_mcause = 32'h8000_0000;
      found    = 0;
      for (int i = 0; i < NIRQ; i++) begin
        if (!found && pend[16+i]) begin
          m_mcause = 32'h8000_0000 + 32'(16 + i);
          found    = 1;
        end
      end
      m_mpie = m_mie;
      m_mie  = 0;
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (w) begin
      if (bus.addr == 12'h300) begin m_mie = nv[3]; m_mpie = nv[7]; end
      if (bus.addr == 12'h341) m_mepc = nv & 32'hFFFF_FFFC;
      if (bus.addr == 12'h342) m_mcause = nv;
    end
    m_mip = 32'(irq) << 16;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".r_data"}, bus.r_data, m_read(bus.addr));
    chk({tag, ".illegal"}, 32'(bus.csr_illegal), 32'(!m_legal(bus.addr)));
    chk({tag, ".pending"}, 32'(intrpt_pending), 32'(m_mie & (|(m_mip & m_mie_r))));
    chk({tag, ".mepc"}, csr_mepc, m_mepc);
    chk({tag, ".mtvec"}, csr_mtvec, m_mtvec);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.w_en = 0; bus.w_op = 2'd3; bus.w_data = 0;
    intrpt_taken = 0; mret = 0; instr_retire = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    bus.w_en = 1; bus.addr = a; bus.w_op = op; bus.w_data = d;
  endtask

  task automatic random_steps(input int n, input string tag);
    logic [11:0] tbl [11];
    tbl = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
            12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0};
    for (int k = 0; k < n; k++) begin
      bus.addr     = tbl[$urandom_range(0, 10)];
      bus.w_en     = ($urandom_range(0, 1) == 1);
      bus.w_op     = 2'($urandom_range(0, 3));
      bus.w_data   = $urandom;
      if ($urandom_range(0, 3) == 0) bus.w_data = bus.w_data | 32'h88;
      irq          = 4'($urandom);
      prog_count   = $urandom;
      intrpt_taken = ($urandom_range(0, 7) == 0);
      mret         = ($urandom_range(0, 7) == 0);
      instr_retire = ($urandom_range(0, 1) == 1);
      step(tag);
    end
    idle();
  endtask

  initial begin
    rst_n = 0; irq = 0; prog_count = 0; bus.addr = 12'h300;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset.mtvec", csr_mtvec, 32'h0000_0100);
    chk("reset.mepc", csr_mepc, 32'd0);
    check_model("reset");
    @(negedge clk);
    rst_n = 1;

    // set then clear MIE through mstatus
    csr_wr(12'h300, 2'd1, 32'h8);
    #1 chk("setclr.old0", bus.r_data, 32'h0);
    step("setclr.set");
    csr_wr(12'h300, 2'd2, 32'h8);
    #1 chk("setclr.read8", bus.r_data, 32'h8);
    step("setclr.clr");
    idle(); bus.addr = 12'h300;
    #1 chk("setclr.read0", bus.r_data, 32'h0);
    step("setclr.after");

    // interrupt entry and mret
    irq = 4'b0110;
    csr_wr(12'h304, 2'd0, 32'h0006_0000);
    step("irq.mie");
    csr_wr(12'h300, 2'd0, 32'h8);
    step("irq.mstatus");
    idle(); bus.addr = 12'h300; intrpt_taken = 1; prog_count = 32'h104;
    #1 chk("irq.pending", 32'(intrpt_pending), 32'd1);
    step("irq.take");
    idle(); bus.addr = 12'h341;
    #1 chk("irq.mepc", bus.r_data, 32'h104);
    step("irq.rd_mepc");
    bus.addr = 12'h342;
    #1 chk("irq.mcause", bus.r_data, 32'h8000_0011);
    step("irq.rd_mcause");
    bus.addr = 12'h300;
    #1 chk("irq.mstatus_trap", bus.r_data, 32'h80);
    mret = 1;
    step("irq.mret");
    mret = 0;
    #1 chk("irq.mstatus_mret", bus.r_data, 32'h88);
    step("irq.after");

    // trap wins over same-cycle mepc write; mtvec write still lands
    intrpt_taken = 1; prog_count = 32'h2A0;
    csr_wr(12'h341, 2'd0, 32'h200);
    step("prio.mepc");
    idle(); bus.addr = 12'h341;
    #1 chk("prio.mepc_val", csr_mepc, 32'h2A0);
    step("prio.rd");
    intrpt_taken = 1; prog_count = 32'h50;
    csr_wr(12'h305, 2'd0, 32'h1003);
    step("prio.mtvec");
    idle();
    #1 chk("prio.mtvec_val", csr_mtvec, 32'h1000);
    step("prio.rd2");

    // mcycle carry across halves and minstret write vs retire
    csr_wr(12'hB80, 2'd0, 32'h0);
    step("cnt.hi");
    csr_wr(12'hB00, 2'd0, 32'hFFFF_FFFF);
    step("cnt.lo");
    idle(); bus.addr = 12'hB00;
    #1 chk("cnt.lo_held", bus.r_data, 32'hFFFF_FFFF);
    step("cnt.rd_lo");
    bus.addr = 12'hB80;
    #1 chk("cnt.carry", bus.r_data, 32'h1);
    step("cnt.rd_hi");
    csr_wr(12'hB02, 2'd0, 32'h1234);
    instr_retire = 1;
    step("cnt.ret_wr");
    idle(); bus.addr = 12'hB02;
    #1 chk("cnt.ret_val", bus.r_data, 32'h1234);
    step("cnt.rd_ret");

    // unmapped address and read-only mip
    bus.addr = 12'h7C0;
    #1 chk("ill.rdata", bus.r_data, 32'h0);
    chk("ill.flag", 32'(bus.csr_illegal), 32'd1);
    step("ill");
    csr_wr(12'h344, 2'd0, 32'hFFFF_FFFF);
    step("mip.wr");
    idle(); bus.addr = 12'h344;
    #1 chk("mip.ro", bus.r_data, 32'h0006_0000);
    step("mip.rd");

    random_steps(300, "rand1");

    // asynchronous reset in the middle of a cycle
    idle(); irq = 0; bus.addr = 12'hB00;
    #1 rst_n = 0;
    #1 chk("arst.mcycle", bus.r_data, 32'h0);
    chk("arst.mtvec", csr_mtvec, 32'h0000_0100);
    chk("arst.mepc", csr_mepc, 32'h0);
    bus.addr = 12'hB82;
    #1 chk("arst.minstreth", bus.r_data, 32'h0);
    bus.addr = 12'h342;
    #1 chk("arst.mcause", bus.r_data, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    random_steps(150, "rand2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
